dpram_line_reader: RTL



---
 rtl/dpram_reader_pkg.sv | 19 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/dpram_line_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dpram_reader_pkg.sv
// ---------------------------------------------------------------------------
// dpram_reader_pkg
// Shared types and constants for the port-B line buffer read engine.
//   rd_state_t  : command FSM states (IDLE, RUN, FINISH)
//   RD_LATENCY  : cycles from presenting an address on port B until the
//                 read data has been captured into the output FIFO; sizes the
//                 in-flight pipe and bounds the issue credit.
// ---------------------------------------------------------------------------
package dpram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } rd_state_t;

  localparam int RD_LATENCY = 2;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the output skid buffer of the line reader.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset (pointers/count)
//   wr_en, wr_data   : push request and data
//   rd_en, rd_data   : pop request and head-of-queue data (show-ahead)
//   count            : current occupancy (0..DEPTH)
//   full, empty      : occupancy flags
// A push and a pop in the same cycle are both performed.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push = wr_en && (!full || rd_en);
  assign pop  = rd_en && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/dpram_line_reader.sv
// ---------------------------------------------------------------------------
// dpram_line_reader
// Streams a run of sequential words out of port B of a dpram line buffer.
// Ports:
//   clk, resetn        : clock (shared with dpram clock_b), async active-low reset
//   start, base, len   : command strobe, first address, beat count (0 = none)
//   busy, done         : command in progress / one-cycle completion pulse
//   rd_addr, rd_data   : port-B address out, registered read data in
//   px_data, px_valid,
//   px_ready, px_last  : valid/ready pixel stream, last flags the final beat
// ---------------------------------------------------------------------------
module dpram_line_reader
  import dpram_reader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_last
);

  localparam int CNT_W  = $clog2(FIFO_D) + 1;
  // The issuing cycle is pipe stage 1; only the later stages are registered.
  localparam int PIPE_N = RD_LATENCY - 1;

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
  logic [PIPE_N-1:0] pipe_v_q, pipe_v_d;
  logic [PIPE_N-1:0] pipe_l_q, pipe_l_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;
  logic [CNT_W:0]    in_flight;
  logic              credit_ok;
  logic              issue;
  logic              issue_last;
  logic              beat_xfer;

  assign busy     = (state_q == RUN);
  assign done     = (state_q == FINISH);
  assign rd_addr  = addr_q;
  assign px_valid = !fifo_empty;
  assign px_data  = fifo_rdata[DATA_W-1:0];
  assign px_last  = !fifo_empty && fifo_rdata[DATA_W];
  assign beat_xfer = px_valid && px_ready;

  // Reads already issued but not yet in the FIFO hold a reserved slot, so the
  // FIFO can absorb every outstanding read even if the consumer stalls.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < PIPE_N; i++) begin
      in_flight = in_flight + {{CNT_W{1'b0}}, pipe_v_q[i]};
    end
  end

  assign credit_ok  = ({1'b0, fifo_count} + in_flight) < (CNT_W + 1)'(FIFO_D);
  assign issue      = (state_q == RUN) && (issue_cnt_q != '0) && credit_ok;
  assign issue_last = issue && (issue_cnt_q == (ADDR_W + 1)'(1));

  always_comb begin
    pipe_v_d    = '0;
    pipe_l_d    = '0;
    pipe_v_d[0] = issue;
    pipe_l_d[0] = issue_last;
    for (int i = 1; i < PIPE_N; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_l_d[i] = pipe_l_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d     = RUN;
            addr_d      = base;
            issue_cnt_d = len;
            beat_cnt_d  = len;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
        end
        if (beat_xfer) begin
          beat_cnt_d = beat_cnt_q - 1'b1;
          if (px_last) begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      pipe_v_q    <= '0;
      pipe_l_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pipe_v_q    <= pipe_v_d;
      pipe_l_q    <= pipe_l_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (pipe_v_q[PIPE_N-1]),
    .wr_data ({pipe_l_q[PIPE_N-1], rd_data}),
    .rd_en   (beat_xfer),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
